// File: rtl/axis_packet_arbiter_if.sv
// Stream bundle for the packet arbiter: N input channels merged onto one output.
// The slave modport is the arbiter side, the master modport the traffic side.
interface axis_packet_arbiter_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int ID_WIDTH       = 4,
   parameter int DEST_WIDTH     = 4,
   parameter int USER_WIDTH     = 4,
   parameter int CHANNEL_NUMBER = 5
);
   typedef struct packed {
      logic [DATA_WIDTH-1:0] tdata;
      logic [ID_WIDTH-1:0]   tid;
      logic [DEST_WIDTH-1:0] tdest;
      logic [USER_WIDTH-1:0] tuser;
      logic                  tlast;
   } axis_data_t;

   axis_data_t                in [CHANNEL_NUMBER];
   logic [CHANNEL_NUMBER-1:0] in_valid;
   logic [CHANNEL_NUMBER-1:0] in_ready;
   axis_data_t                out;
   logic                      out_valid;
   logic                      out_ready;
   logic                      drop_pulse;

   modport master (
      output in, in_valid, out_ready,
      input  in_ready, out, out_valid, drop_pulse
   );

   modport slave (
      input  in, in_valid, out_ready,
      output in_ready, out, out_valid, drop_pulse
   );
endinterface

// File: rtl/axis_packet_arbiter.sv
// Round-robin packet arbiter: locks onto a channel from header to TLAST,
// discards stray non-header beats while idle, one-entry output register.
module axis_packet_arbiter #(
   parameter int DATA_WIDTH           = 32,
   parameter int ID_WIDTH             = 4,
   parameter int DEST_WIDTH           = 4,
   parameter int USER_WIDTH           = 4,
   parameter int CHANNEL_NUMBER       = 5,
   parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
   parameter logic [ID_WIDTH-1:0] ROUTING_HEADER = 'hA
) (
   input logic                   clk,
   input logic                   rst,
   axis_packet_arbiter_if.slave  bus
);
   localparam int CW = CHANNEL_NUMBER_WIDTH;
   localparam logic [CW:0]   N_EXT = (CW+1)'(CHANNEL_NUMBER);
   localparam logic [CW-1:0] N_M1  = CW'(CHANNEL_NUMBER - 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] tdata;
      logic [ID_WIDTH-1:0]   tid;
      logic [DEST_WIDTH-1:0] tdest;
      logic [USER_WIDTH-1:0] tuser;
      logic                  tlast;
   } axis_data_t;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t     state_q, state_d;
   logic [CW-1:0] grant_q, grant_d;
   logic [CW-1:0] rr_ptr_q, rr_ptr_d;
   axis_data_t out_q, out_d;
   logic       out_valid_q, out_valid_d;

   logic [CHANNEL_NUMBER-1:0] hdr, stray, in_ready_c;
   logic          drop_c, found, acc, can_load;
   logic [CW-1:0] win, acc_ch;
   logic [CW:0]   idx;
   axis_data_t    beat;

   always_comb begin
      hdr   = '0;
      stray = '0;
      for (int i = 0; i < CHANNEL_NUMBER; i++) begin
         hdr[i]   = bus.in_valid[i] && (bus.in[i].tid == ROUTING_HEADER);
         stray[i] = bus.in_valid[i] && (bus.in[i].tid != ROUTING_HEADER);
      end
   end

   // first header found scanning upward from rr_ptr, with wrap
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < CHANNEL_NUMBER; k++) begin
         idx = {1'b0, rr_ptr_q} + (CW+1)'(k);
         if (idx >= N_EXT) idx = idx - N_EXT;
         if (!found && hdr[idx[CW-1:0]]) begin
            found = 1'b1;
            win   = idx[CW-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      in_ready_c  = '0;
      drop_c      = 1'b0;
      acc         = 1'b0;
      acc_ch      = '0;
      can_load    = !out_valid_q || bus.out_ready;
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               in_ready_c = stray;
               drop_c     = |stray;
               if (found) begin
                  in_ready_c[win] = can_load;
                  acc    = can_load;
                  acc_ch = win;
               end
            end
            LOCKED: begin
               in_ready_c[grant_q] = can_load;
               acc    = can_load && bus.in_valid[grant_q];
               acc_ch = grant_q;
            end
            default: ;
         endcase
      end
      beat = bus.in[acc_ch];
      if (acc) begin
         out_d       = beat;
         out_valid_d = 1'b1;
         if (state_q == IDLE) begin
            rr_ptr_d = (acc_ch == N_M1) ? '0 : acc_ch + 1'b1;
            if (!beat.tlast) begin
               state_d = LOCKED;
               grant_d = acc_ch;
            end
         end else if (beat.tlast) begin
            state_d = IDLE;
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.drop_pulse = drop_c;
   assign bus.out        = out_q;
   assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: directed cycle table, reset sequences,
// and random traffic against a packet-level reference model.
module tb_axis_packet_arbiter;
   localparam int N = 5;
   localparam logic [3:0] RH = 4'hA;

   typedef struct packed {
      logic [31:0] tdata;
      logic [3:0]  tid;
      logic [3:0]  tdest;
      logic [3:0]  tuser;
      logic        tlast;
   } beat_t;

   typedef struct {
      logic [4:0] vld;
      logic [4:0] hdr;
      logic [4:0] last;
      logic       ordy;
      logic [4:0] rdy;
      logic       drop;
      logic       ov;
      int         sch;
      int         sstep;
   } vec_t;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   axis_packet_arbiter_if #(
      .DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4),
      .USER_WIDTH(4), .CHANNEL_NUMBER(N)
   ) bus ();

   axis_packet_arbiter #(
      .DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4),
      .USER_WIDTH(4), .CHANNEL_NUMBER(N),
      .ROUTING_HEADER(RH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)",
                  nm, got, exp, $time);
      end
   endtask

   function automatic beat_t mk(input int ch, input int st,
                                input logic h, input logic l);
      beat_t b;
      b.tdata = 32'(ch * 256 + st);
      b.tid   = h ? RH : (RH ^ 4'h1);
      b.tdest = 4'(ch);
      b.tuser = 4'(st);
      b.tlast = l;
      return b;
   endfunction

   function automatic vec_t mv(
      input logic [4:0] vld, input logic [4:0] hdr,
      input logic [4:0] last, input logic ordy,
      input logic [4:0] rdy, input logic drop,
      input logic ov, input int sch, input int sstep);
      vec_t v;
      v.vld = vld; v.hdr = hdr; v.last = last; v.ordy = ordy;
      v.rdy = rdy; v.drop = drop; v.ov = ov;
      v.sch = sch; v.sstep = sstep;
      return v;
   endfunction

   task automatic drive(input logic [4:0] vld, input logic [4:0] hdr,
                        input logic [4:0] last, input logic ordy,
                        input int st);
      for (int c = 0; c < N; c++)
         bus.in[c] = mk(c, st, hdr[3'(c)], last[3'(c)]);
      bus.in_valid  = vld;
      bus.out_ready = ordy;
   endtask

   vec_t  tbl [21];
   beat_t bt  [N];
   beat_t eb;
   logic [4:0] e_rdy;
   logic  e_drop;
   bit    m_lock;
   int    m_own;
   int    m_rr;
   bit    m_ov;
   beat_t m_out;

   initial begin
      n_chk = 0;
      n_fail = 0;
      // vld hdr last ordy | rdy drop ov src_ch src_step
      tbl[0]  = mv(5'b01010, 5'b01010, 5'b00000, 1, 5'b00010, 0, 0, 0, 0);
      tbl[1]  = mv(5'b01010, 5'b01000, 5'b00000, 1, 5'b00010, 0, 1, 1, 0);
      tbl[2]  = mv(5'b01010, 5'b01000, 5'b00010, 1, 5'b00010, 0, 1, 1, 1);
      tbl[3]  = mv(5'b01000, 5'b01000, 5'b00000, 1, 5'b01000, 0, 1, 1, 2);
      tbl[4]  = mv(5'b11000, 5'b00000, 5'b01000, 1, 5'b01000, 0, 1, 3, 3);
      tbl[5]  = mv(5'b10000, 5'b00000, 5'b00000, 1, 5'b10000, 1, 1, 3, 4);
      tbl[6]  = mv(5'b00100, 5'b00100, 5'b00100, 1, 5'b00100, 0, 0, 0, 0);
      tbl[7]  = mv(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 1, 2, 6);
      tbl[8]  = mv(5'b11001, 5'b11001, 5'b11001, 1, 5'b01000, 0, 0, 0, 0);
      tbl[9]  = mv(5'b11001, 5'b11001, 5'b11001, 1, 5'b10000, 0, 1, 3, 8);
      tbl[10] = mv(5'b11001, 5'b11001, 5'b11001, 1, 5'b00001, 0, 1, 4, 9);
      tbl[11] = mv(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 1, 0, 10);
      tbl[12] = mv(5'b00001, 5'b00001, 5'b00000, 1, 5'b00001, 0, 0, 0, 0);
      tbl[13] = mv(5'b00101, 5'b00100, 5'b00000, 0, 5'b00000, 0, 1, 0, 12);
      tbl[14] = mv(5'b00101, 5'b00100, 5'b00000, 0, 5'b00000, 0, 1, 0, 12);
      tbl[15] = mv(5'b00101, 5'b00100, 5'b00000, 0, 5'b00000, 0, 1, 0, 12);
      tbl[16] = mv(5'b00101, 5'b00100, 5'b00000, 1, 5'b00001, 0, 1, 0, 12);
      tbl[17] = mv(5'b00101, 5'b00100, 5'b00101, 1, 5'b00001, 0, 1, 0, 16);
      tbl[18] = mv(5'b00100, 5'b00100, 5'b00100, 1, 5'b00100, 0, 1, 0, 17);
      tbl[19] = mv(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 1, 2, 18);
      tbl[20] = mv(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);

      // reset with stray traffic present
      rst = 1'b1;
      drive(5'b11111, 5'b00000, 5'b00000, 1'b1, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_drop", 64'(bus.drop_pulse), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out", 64'(bus.out), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      drive(5'b00000, 5'b00000, 5'b00000, 1'b1, 0);

      // directed cycle table
      for (int k = 0; k < 21; k++) begin
         drive(tbl[k].vld, tbl[k].hdr, tbl[k].last, tbl[k].ordy, k);
         @(negedge clk);
         chk($sformatf("tbl%0d_in_ready", k),
             64'(bus.in_ready), 64'(tbl[k].rdy));
         chk($sformatf("tbl%0d_drop", k),
             64'(bus.drop_pulse), 64'(tbl[k].drop));
         chk($sformatf("tbl%0d_out_valid", k),
             64'(bus.out_valid), 64'(tbl[k].ov));
         if (tbl[k].ov) begin
            eb = mk(tbl[k].sch, tbl[k].sstep,
                    tbl[tbl[k].sstep].hdr[3'(tbl[k].sch)],
                    tbl[tbl[k].sstep].last[3'(tbl[k].sch)]);
            chk($sformatf("tbl%0d_out", k), 64'(bus.out), 64'(eb));
         end
         @(posedge clk);
         #1;
      end

      // reset during the 2nd beat of a packet on ch1
      drive(5'b00010, 5'b00010, 5'b00000, 1'b1, 40);
      @(posedge clk);
      #1 drive(5'b00010, 5'b00000, 5'b00000, 1'b1, 41);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      drive(5'b01010, 5'b01000, 5'b01000, 1'b1, 42);
      @(negedge clk);
      chk("postrst_in_ready", 64'(bus.in_ready), 64'b01010);
      chk("postrst_drop", 64'(bus.drop_pulse), 64'd1);
      chk("postrst_out_valid0", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1 drive(5'b00000, 5'b00000, 5'b00000, 1'b1, 43);
      @(negedge clk);
      chk("postrst_out_valid1", 64'(bus.out_valid), 64'd1);
      chk("postrst_out", 64'(bus.out), 64'(mk(3, 42, 1'b1, 1'b1)));

      // random traffic against the packet-level model
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      m_lock = 0; m_own = 0; m_rr = 0; m_ov = 0; m_out = '0;
      repeat (3000) begin
         logic [4:0] vld;
         logic ordy;
         logic can;
         int acc;
         int w;
         for (int c = 0; c < N; c++) begin
            bt[c].tdata = $urandom;
            bt[c].tid   = ($urandom_range(99) < 45) ? RH : 4'($urandom);
            bt[c].tdest = 4'($urandom);
            bt[c].tuser = 4'($urandom);
            bt[c].tlast = ($urandom_range(2) == 0);
            vld[3'(c)]  = ($urandom_range(1) == 1);
            bus.in[c]   = bt[c];
         end
         ordy = ($urandom_range(9) < 7);
         bus.in_valid  = vld;
         bus.out_ready = ordy;
         @(negedge clk);
         can = !m_ov || ordy;
         e_rdy = '0;
         e_drop = 1'b0;
         acc = -1;
         if (m_lock) begin
            e_rdy[3'(m_own)] = can;
            if (can && vld[3'(m_own)]) acc = m_own;
         end else begin
            for (int c = 0; c < N; c++)
               if (vld[3'(c)] && bt[c].tid != RH) begin
                  e_rdy[3'(c)] = 1'b1;
                  e_drop = 1'b1;
               end
            w = -1;
            for (int k = 0; k < N; k++) begin
               int c;
               c = (m_rr + k) % N;
               if (w < 0 && vld[3'(c)] && bt[c].tid == RH) w = c;
            end
            if (w >= 0) begin
               e_rdy[3'(w)] = can;
               if (can) acc = w;
            end
         end
         chk("rnd_in_ready", 64'(bus.in_ready), 64'(e_rdy));
         chk("rnd_drop", 64'(bus.drop_pulse), 64'(e_drop));
         chk("rnd_out_valid", 64'(bus.out_valid), 64'(m_ov));
         if (m_ov) chk("rnd_out", 64'(bus.out), 64'(m_out));
         if (acc >= 0) begin
            if (!m_lock) begin
               m_rr = (acc + 1) % N;
               if (!bt[acc].tlast) begin
                  m_lock = 1;
                  m_own = acc;
               end
            end else if (bt[acc].tlast) begin
               m_lock = 0;
            end
            m_out = bt[acc];
            m_ov = 1;
         end else if (ordy) begin
            m_ov = 0;
         end
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
